// File: rtl/md5_pkg.sv
// rtl/md5_pkg.sv - shared MD5 constants, scheduler state encoding and digest layout helpers
package md5_pkg;

    localparam int BLOCK_WORDS = 16;
    localparam int WORD_W      = 32;
    localparam int WADDR_W     = 4;
    localparam int DIGEST_W    = 128;

    localparam logic [WORD_W-1:0] MD5_IV_A = 32'h67452301;
    localparam logic [WORD_W-1:0] MD5_IV_B = 32'hefcdab89;
    localparam logic [WORD_W-1:0] MD5_IV_C = 32'h98badcfe;
    localparam logic [WORD_W-1:0] MD5_IV_D = 32'h10325476;

    // Digests travel as {d,c,b,a}, i.e. word a sits in the low 32 bits.
    localparam logic [DIGEST_W-1:0] MD5_IV = {MD5_IV_D, MD5_IV_C, MD5_IV_B, MD5_IV_A};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_CMP   = 3'd4,
        ST_HALT  = 3'd5
    } sched_state_t;

    function automatic logic [DIGEST_W-1:0] pack_digest(
        input logic [WORD_W-1:0] a,
        input logic [WORD_W-1:0] b,
        input logic [WORD_W-1:0] c,
        input logic [WORD_W-1:0] d
    );
        return {d, c, b, a};
    endfunction

    // Select word 0=a, 1=b, 2=c, 3=d from a {d,c,b,a} digest.
    function automatic logic [WORD_W-1:0] digest_word(
        input logic [DIGEST_W-1:0] dg,
        input logic [1:0]          sel
    );
        logic [WORD_W-1:0] w;
        case (sel)
            2'd0:    w = dg[31:0];
            2'd1:    w = dg[63:32];
            2'd2:    w = dg[95:64];
            default: w = dg[127:96];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/msg_pingpong.sv
// rtl/msg_pingpong.sv - two-bank candidate block buffer with word-serial fill and crunch-side read port
module msg_pingpong
    import md5_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WORD_W-1:0]  in_data,
    input  logic               halted,
    input  logic               release_bank,
    output logic               crunch_full,
    input  logic [WADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0]  rd_data
);

    logic [WORD_W-1:0]  bank_q [2][BLOCK_WORDS];
    logic [1:0]         full_q, full_d;
    logic               fill_ptr_q, fill_ptr_d;
    logic               crunch_ptr_q, crunch_ptr_d;
    logic [WADDR_W-1:0] wcnt_q, wcnt_d;
    logic               accept;

    // Fill-side handshake, bank release from the crunch side and pointer/flag updates.
    // A full bank is never filled, so set and clear never hit the same flag together.
    always_comb begin
        in_ready     = !full_q[fill_ptr_q] && !halted;
        accept       = in_valid && in_ready;
        full_d       = full_q;
        fill_ptr_d   = fill_ptr_q;
        crunch_ptr_d = crunch_ptr_q;
        wcnt_d       = wcnt_q;
        if (release_bank) begin
            full_d[crunch_ptr_q] = 1'b0;
            crunch_ptr_d         = ~crunch_ptr_q;
        end
        if (accept) begin
            wcnt_d = wcnt_q + 4'd1;
            if (wcnt_q == 4'(BLOCK_WORDS - 1)) begin
                full_d[fill_ptr_q] = 1'b1;
                fill_ptr_d         = ~fill_ptr_q;
            end
        end
    end

    // Control state; reset empties both banks and rewinds every pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            full_q       <= 2'b00;
            fill_ptr_q   <= 1'b0;
            crunch_ptr_q <= 1'b0;
            wcnt_q       <= '0;
        end else begin
            full_q       <= full_d;
            fill_ptr_q   <= fill_ptr_d;
            crunch_ptr_q <= crunch_ptr_d;
            wcnt_q       <= wcnt_d;
        end
    end

    // Word storage; contents need no reset because the full flags gate their use.
    always_ff @(posedge clk) begin
        if (!reset && accept) begin
            bank_q[fill_ptr_q][wcnt_q] <= in_data;
        end
    end

    assign crunch_full = full_q[crunch_ptr_q];
    assign rd_data     = bank_q[crunch_ptr_q][rd_addr];

endmodule

// File: rtl/chunk_scheduler.sv
// rtl/chunk_scheduler.sv - sequences one MD5 cruncher over buffered candidate blocks and reports matches
module chunk_scheduler
    import md5_pkg::*;
#(
    parameter int IDX_W         = 32,
    parameter bit STOP_ON_MATCH = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WORD_W-1:0]   in_data,
    input  logic [DIGEST_W-1:0] target,
    output logic                cr_reset,
    output logic                cr_start,
    input  logic                cr_done,
    input  logic [DIGEST_W-1:0] cr_digest,
    input  logic [WADDR_W-1:0]  cr_gaddr,
    output logic [WORD_W-1:0]   cr_mdata,
    output logic                res_valid,
    input  logic                res_ready,
    output logic                res_match,
    output logic [IDX_W-1:0]    res_index,
    output logic                halted
);

    sched_state_t     state_q, state_d;
    logic [IDX_W-1:0] seq_q, seq_d;
    logic             match_q, match_d;
    logic             first_q, first_d;
    logic             release_bank;
    logic             crunch_full;

    msg_pingpong u_buf (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .halted       (halted),
        .release_bank (release_bank),
        .crunch_full  (crunch_full),
        .rd_addr      (cr_gaddr),
        .rd_data      (cr_mdata)
    );

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            seq_q   <= '0;
            match_q <= 1'b0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            match_q <= match_d;
            first_q <= first_d;
        end
    end

    // Next state, digest comparison and bank release. The first WAIT cycle ignores
    // cr_done because the cruncher may still show done from its previous block.
    always_comb begin
        state_d      = state_q;
        seq_d        = seq_q;
        match_d      = match_q;
        first_d      = 1'b0;
        release_bank = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (crunch_full) state_d = ST_CLR;
            end
            ST_CLR: begin
                state_d = ST_START;
            end
            ST_START: begin
                state_d = ST_WAIT;
                first_d = 1'b1;
            end
            ST_WAIT: begin
                if (!first_q && cr_done) begin
                    match_d      = (cr_digest == target);
                    release_bank = 1'b1;
                    state_d      = ST_CMP;
                end
            end
            ST_CMP: begin
                if (res_ready) begin
                    seq_d = seq_q + IDX_W'(1);
                    if (match_q && STOP_ON_MATCH) begin
                        state_d = ST_HALT;
                    end else if (crunch_full) begin
                        state_d = ST_CLR;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs. cr_reset follows the block reset so the cruncher is cleared with us;
    // cr_start is masked by reset so the two never coincide.
    always_comb begin
        cr_reset  = reset || (state_q == ST_CLR);
        cr_start  = !reset && (state_q == ST_START);
        res_valid = (state_q == ST_CMP);
        res_match = match_q;
        res_index = seq_q;
        halted    = (state_q == ST_HALT);
    end

endmodule

// File: tb/tb_chunk_scheduler.sv
// tb/tb_chunk_scheduler.sv - randomized self-checking bench with behavioural MD5 cruncher and result model
module tb_chunk_scheduler;
    import md5_pkg::*;

    localparam int IDX_W = 32;
    localparam logic [127:0] EMPTY_DG = 128'h7e42f8ec_980980e9_04b2008f_d98c1dd4;

    localparam logic [31:0] K_TAB [64] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
        32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
        32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
        32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
        32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
        32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_data;
    logic [127:0]      target;
    logic              cr_reset;
    logic              cr_start;
    logic              cr_done;
    logic [127:0]      cr_digest;
    logic [3:0]        cr_gaddr;
    logic [31:0]       cr_mdata;
    logic              res_valid;
    logic              res_ready;
    logic              res_match;
    logic [IDX_W-1:0]  res_index;
    logic              halted;

    always #5 clk = ~clk;

    chunk_scheduler #(.IDX_W(IDX_W), .STOP_ON_MATCH(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .target    (target),
        .cr_reset  (cr_reset),
        .cr_start  (cr_start),
        .cr_done   (cr_done),
        .cr_digest (cr_digest),
        .cr_gaddr  (cr_gaddr),
        .cr_mdata  (cr_mdata),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_match (res_match),
        .res_index (res_index),
        .halted    (halted)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] x, input int s);
        return (x << s) | (x >> (32 - s));
    endfunction

    function automatic int shamt(input int i);
        int r;
        r = i % 4;
        case (i / 16)
            0:       return (r == 0) ? 7 : (r == 1) ? 12 : (r == 2) ? 17 : 22;
            1:       return (r == 0) ? 5 : (r == 1) ? 9  : (r == 2) ? 14 : 20;
            2:       return (r == 0) ? 4 : (r == 1) ? 11 : (r == 2) ? 16 : 23;
            default: return (r == 0) ? 6 : (r == 1) ? 10 : (r == 2) ? 15 : 21;
        endcase
    endfunction

    // Reference MD5 compression of one 16-word block from the standard IV.
    function automatic logic [127:0] md5_blk(input logic [31:0] m [16]);
        logic [31:0] a, b, c, d, f, t;
        int g;
        a = MD5_IV_A; b = MD5_IV_B; c = MD5_IV_C; d = MD5_IV_D;
        for (int i = 0; i < 64; i++) begin
            case (i / 16)
                0:       begin f = (b & c) | (~b & d); g = i;                end
                1:       begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
                2:       begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
                default: begin f = c ^ (b | ~d);       g = (7 * i) % 16;     end
            endcase
            t = d; d = c; c = b;
            b = b + rotl(a + f + K_TAB[i] + m[g], shamt(i));
            a = t;
        end
        return {d + MD5_IV_D, c + MD5_IV_C, b + MD5_IV_B, a + MD5_IV_A};
    endfunction

    // Behavioural cruncher: reads the 16 words in its first 16 busy cycles, done after 260.
    int          cr_cnt = 0;
    logic        cr_busy = 1'b0;
    logic [31:0] cr_w [16];
    assign cr_gaddr = cr_cnt[3:0];

    always @(posedge clk) begin
        if (cr_reset) begin
            cr_busy <= 1'b0; cr_done <= 1'b0; cr_cnt <= 0; cr_digest <= '0;
        end else if (cr_start) begin
            cr_busy <= 1'b1; cr_done <= 1'b0; cr_cnt <= 0;
        end else if (cr_busy) begin
            if (cr_cnt < 16) cr_w[cr_cnt[3:0]] <= cr_mdata;
            if (cr_cnt == 259) begin
                cr_busy <= 1'b0; cr_done <= 1'b1; cr_digest <= md5_blk(cr_w);
            end
            cr_cnt <= cr_cnt + 1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Result model: buffered block count, expected results in order, index and halt state.
    int          occ_m = 0;
    int          wpos_m = 0;
    logic [31:0] blk_m [16];
    bit          exp_q [$];
    logic [31:0] idx_m = 0;
    bit          halted_m = 0;
    logic        prev_rv = 0;
    logic        prev_crr = 1;
    int          n_start = 0;
    bit          gap_chk = 0;
    bit          hs_pending = 0;
    int          last_hs = 0;

    always @(negedge clk) begin
        if (reset) begin
            occ_m = 0; wpos_m = 0; exp_q.delete(); idx_m = 0; halted_m = 0;
            prev_rv = 0; prev_crr = 1; hs_pending = 0;
        end else begin
            if (cr_start) begin
                n_start++;
                chk("start_with_reset", cr_reset, 1'b0);
                chk("start_after_clr", prev_crr, 1'b1);
                if (gap_chk && hs_pending) chk("start_gap_le3", (cyc - last_hs) <= 3, 1'b1);
                hs_pending = 0;
            end
            if (res_valid && !prev_rv) occ_m--;
            chk("in_ready", in_ready, (occ_m < 2) && !halted_m);
            chk("halted", halted, halted_m);
            if (in_valid && in_ready) begin
                blk_m[wpos_m] = in_data;
                if (wpos_m == 15) begin
                    exp_q.push_back(md5_blk(blk_m) == target);
                    occ_m++;
                    wpos_m = 0;
                end else begin
                    wpos_m++;
                end
            end
            if (res_valid && res_ready) begin
                chk("result_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    bit e;
                    e = exp_q.pop_front();
                    chk("res_match", res_match, e);
                    chk("res_index", res_index, idx_m);
                    if (e) halted_m = 1;
                end
                idx_m++;
                hs_pending = 1;
                last_hs = cyc;
            end
            prev_rv = res_valid;
            prev_crr = cr_reset;
        end
    end

    task automatic send_words(input logic [31:0] w [16], input int n, input int max_gap, output int acc_cyc);
        acc_cyc = cyc;
        for (int i = 0; i < n; i++) begin
            int t;
            bit ok;
            in_valid = 1'b1; in_data = w[i]; t = 0; ok = 0;
            while (!ok && t < 600) begin
                @(negedge clk); ok = in_ready; @(posedge clk); #1; t++;
            end
            in_valid = 1'b0;
            if (!ok) begin
                chk("accept_timeout", ok, 1'b1);
                return;
            end
            acc_cyc = cyc;
            repeat ($urandom_range(max_gap, 0)) begin @(posedge clk); #1; end
        end
    endtask

    task automatic wait_res(input int limit);
        int n;
        n = 0;
        @(negedge clk);
        while (!res_valid && n < limit) begin @(negedge clk); n++; end
        chk("res_seen", res_valid, 1'b1);
    endtask

    task automatic wait_idx(input logic [31:0] want, input int limit);
        int n;
        n = 0;
        while (idx_m != want && n < limit) begin @(negedge clk); n++; end
        chk("result_count", idx_m, want);
    endtask

    task automatic do_reset();
        @(posedge clk); #1; reset = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0;
    endtask

    task automatic rand_blk(output logic [31:0] w [16]);
        for (int i = 0; i < 16; i++) w[i] = $urandom;
    endtask

    logic [31:0] blk_a [16];
    logic [31:0] blk_b [16];
    logic [31:0] blk_c [16];
    int          c0;
    int          s0;

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; res_ready = 1'b0; target = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cr_reset", cr_reset, 1'b1);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_cr_start", cr_start, 1'b0);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_res_match", res_match, 1'b0);
        chk("rst_res_index", res_index, 0);
        chk("rst_halted", halted, 1'b0);
        @(posedge clk); #1; reset = 1'b0;

        // Empty message matches its own digest and halts the block.
        for (int i = 0; i < 16; i++) blk_a[i] = 32'h0;
        blk_a[0] = 32'h00000080;
        chk("model_empty_digest", md5_blk(blk_a), EMPTY_DG);
        target = EMPTY_DG; res_ready = 1'b1;
        send_words(blk_a, 16, 0, c0);
        wait_res(300);
        chk("t1_latency_le270", (cyc - c0) <= 270, 1'b1);
        chk("t1_match", res_match, 1'b1);
        chk("t1_index", res_index, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t1_halted", halted, 1'b1);
        chk("t1_in_ready", in_ready, 1'b0);
        s0 = n_start;
        in_valid = 1'b1; in_data = 32'h1234;
        repeat (20) begin @(posedge clk); #1; end
        in_valid = 1'b0;
        chk("t1_no_start", n_start, s0);

        // "abc" against the empty digest: no match, back to idle.
        do_reset();
        for (int i = 0; i < 16; i++) blk_a[i] = 32'h0;
        blk_a[0] = 32'h80636261; blk_a[14] = 32'h00000018;
        send_words(blk_a, 16, 2, c0);
        wait_res(300);
        chk("t2_latency_le270", (cyc - c0) <= 270, 1'b1);
        chk("t2_match", res_match, 1'b0);
        chk("t2_index", res_index, 0);
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("t2_halted", halted, 1'b0);
        chk("t2_res_valid", res_valid, 1'b0);
        chk("t2_in_ready", in_ready, 1'b1);

        // Three blocks streamed back to back; the last one matches.
        do_reset();
        rand_blk(blk_a); rand_blk(blk_b); rand_blk(blk_c);
        target = md5_blk(blk_c);
        gap_chk = 1;
        send_words(blk_a, 16, 0, c0);
        send_words(blk_b, 16, 0, c0);
        send_words(blk_c, 16, 0, c0);
        wait_idx(3, 1500);
        gap_chk = 0;
        @(negedge clk);
        chk("t3_halted", halted, 1'b1);

        // Consumer stalls 50 cycles on the first result while the other bank fills.
        do_reset();
        rand_blk(blk_a); rand_blk(blk_b); rand_blk(blk_c);
        target = md5_blk(blk_b); res_ready = 1'b0;
        send_words(blk_a, 16, 1, c0);
        send_words(blk_b, 16, 1, c0);
        wait_res(400);
        s0 = n_start;
        in_valid = 1'b1; in_data = blk_c[0];
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", res_valid, 1'b1);
            chk("t4_hold_match", res_match, 1'b0);
            chk("t4_hold_index", res_index, 0);
        end
        chk("t4_no_start", n_start, s0);
        @(posedge clk); #1;
        in_valid = 1'b0; res_ready = 1'b1;
        wait_idx(2, 700);
        @(negedge clk);
        chk("t4_halted", halted, 1'b1);

        // Reset in the middle of a crunch with a partly loaded second bank.
        do_reset();
        rand_blk(blk_a); rand_blk(blk_b); rand_blk(blk_c);
        target = {$urandom, $urandom, $urandom, $urandom};
        send_words(blk_a, 16, 0, c0);
        repeat (30) begin @(posedge clk); #1; end
        send_words(blk_b, 7, 1, c0);
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t5_cr_reset", cr_reset, 1'b1);
        chk("t5_res_valid", res_valid, 1'b0);
        chk("t5_in_ready", in_ready, 1'b1);
        @(posedge clk); #1; reset = 1'b0;
        send_words(blk_c, 16, 0, c0);
        wait_res(300);
        chk("t5_latency_le270", (cyc - c0) <= 270, 1'b1);
        chk("t5_index", res_index, 0);
        chk("t5_match", res_match, md5_blk(blk_c) == target);
        repeat (3) begin @(posedge clk); #1; end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        errors++;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

endmodule
